mem_unit_way0: RTL

Way-0 memory-access stage. It sits between the way-0 execute stage and the way-0 writeback register. ALU results pass straight through. Loads and stores are sequenced on the data bus by a four-state FSM. Load data is aligned and sign/zero-extended, and the stage stalls upstream while a bus transaction is in flight. Its outputs feed the writeback register's rd/valid/pID inputs directly.

---
 rtl/b8_mem_pkg.sv | 45 ++++
 rtl/mem_load_align.sv | 37 +++
 rtl/mem_unit_way0.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/b8_mem_pkg.sv
// Shared definitions for the way-0/way-1 memory-access stages: FSM states,
// load/store size codes and byte-enable mask generation.
package b8_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } mem_state_t;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LD  = 3'd3;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [2:0] LWU = 3'd6;

  // Access size lives in funct3[1:0]; the shift truncates to the 8 lanes.
  function automatic logic [7:0] mem_mask(input logic [2:0] funct3,
                                          input logic [2:0] addr_lo);
    logic [7:0] mask;
    case (funct3[1:0])
      2'd0:    mask = 8'h01 << addr_lo;
      2'd1:    mask = 8'h03 << addr_lo;
      2'd2:    mask = 8'h0F << addr_lo;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

  function automatic logic mem_misaligned(input logic [2:0] funct3,
                                          input logic [2:0] addr_lo);
    logic bad;
    case (funct3[1:0])
      2'd0:    bad = 1'b0;
      2'd1:    bad = addr_lo[0];
      2'd2:    bad = |addr_lo[1:0];
      default: bad = |addr_lo;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-data alignment: moves the addressed lane down to bit 0 and applies
// sign or zero extension according to funct3. Shared by both ways.
module mem_load_align
  import b8_mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      funct3,
  input  logic [2:0]      addr_lo,
  input  logic [XLEN-1:0] raw_data,
  output logic [XLEN-1:0] rd_data
);

  logic [XLEN-1:0]   shifted;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;
  logic signed [31:0] word_s;

  assign shifted = raw_data >> {addr_lo, 3'b000};
  assign byte_s  = $signed(shifted[7:0]);
  assign half_s  = $signed(shifted[15:0]);
  assign word_s  = $signed(shifted[31:0]);

  always_comb begin
    rd_data = shifted;
    case (funct3)
      LB:      rd_data = XLEN'(byte_s);
      LH:      rd_data = XLEN'(half_s);
      LW:      rd_data = XLEN'(word_s);
      LBU:     rd_data = XLEN'(shifted[7:0]);
      LHU:     rd_data = XLEN'(shifted[15:0]);
      LWU:     rd_data = XLEN'(shifted[31:0]);
      default: rd_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_unit_way0.sv
// Way-0 memory-access stage: ALU results pass through, loads/stores are
// sequenced on the data bus and the stage stalls upstream while busy.
module mem_unit_way0
  import b8_mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            memRead_i,
  input  logic            memWrite_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] memAddr_i,
  input  logic [XLEN-1:0] storeData_i,
  input  logic            rdWriteEnable_i,
  input  logic [4:0]      rdAddr_i,
  input  logic [XLEN-1:0] aluResult_i,
  input  logic [1:0]      pID_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic            rdWriteEnable_o,
  output logic [4:0]      rdAddr_o,
  output logic [XLEN-1:0] rdData_o,
  output logic [1:0]      pID_o,
  output logic            excMisalign_o,
  output logic            memReqValid_o,
  output logic            memReqWrite_o,
  output logic [XLEN-1:0] memReqAddr_o,
  output logic [XLEN-1:0] memReqWdata_o,
  output logic [7:0]      memReqMask_o,
  input  logic            memReqReady_i,
  input  logic            memRespValid_i,
  input  logic [XLEN-1:0] memRespData_i
);

  mem_state_t state_q, state_d;

  logic            is_mem;
  logic            misalign;
  logic            accept_mem;
  logic            start_req;
  logic            resp_capture;

  logic [4:0]      rd_addr_q;
  logic            rd_we_q;
  logic [1:0]      pid_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] store_data_q;
  logic            is_write_q;
  logic [XLEN-1:0] resp_data_q;
  logic            exc_q;
  logic [XLEN-1:0] load_data;

  assign is_mem     = memRead_i | memWrite_i;
  assign misalign   = mem_misaligned(funct3_i, memAddr_i[2:0]);
  assign accept_mem = (state_q == IDLE) & valid_i & ready_i & is_mem;
  assign start_req  = accept_mem & ~misalign;

  always_comb begin
    state_d      = state_q;
    resp_capture = 1'b0;
    case (state_q)
      IDLE: if (start_req) state_d = REQ;
      REQ: begin
        // A same-cycle response skips WAIT entirely.
        if (memReqReady_i) begin
          if (memRespValid_i) begin
            state_d      = RESP;
            resp_capture = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (memRespValid_i) begin
          state_d      = RESP;
          resp_capture = 1'b1;
        end
      end
      RESP: if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      exc_q   <= accept_mem & misalign;
    end
  end

  // Holding registers: instruction context captured at accept, bus data at response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr_q    <= '0;
      rd_we_q      <= 1'b0;
      pid_q        <= '0;
      funct3_q     <= '0;
      addr_q       <= '0;
      store_data_q <= '0;
      is_write_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      if (start_req) begin
        rd_addr_q    <= rdAddr_i;
        rd_we_q      <= rdWriteEnable_i;
        pid_q        <= pID_i;
        funct3_q     <= funct3_i;
        addr_q       <= memAddr_i;
        store_data_q <= storeData_i;
        is_write_q   <= memWrite_i;
      end
      if (resp_capture) resp_data_q <= memRespData_i;
    end
  end

  mem_load_align #(.XLEN(XLEN)) u_load_align (
    .funct3   (funct3_q),
    .addr_lo  (addr_q[2:0]),
    .raw_data (resp_data_q),
    .rd_data  (load_data)
  );

  assign excMisalign_o = exc_q;

  always_comb begin
    ready_o         = 1'b0;
    valid_o         = 1'b0;
    rdWriteEnable_o = 1'b0;
    rdAddr_o        = '0;
    rdData_o        = '0;
    pID_o           = '0;
    memReqValid_o   = 1'b0;
    memReqWrite_o   = 1'b0;
    memReqAddr_o    = '0;
    memReqWdata_o   = '0;
    memReqMask_o    = '0;
    case (state_q)
      IDLE: begin
        ready_o = ready_i;
        if (valid_i && !is_mem) begin
          valid_o         = 1'b1;
          rdWriteEnable_o = rdWriteEnable_i;
          rdAddr_o        = rdAddr_i;
          rdData_o        = aluResult_i;
          pID_o           = pID_i;
        end
      end
      REQ: begin
        memReqValid_o = 1'b1;
        memReqWrite_o = is_write_q;
        memReqAddr_o  = {addr_q[XLEN-1:3], 3'b000};
        memReqMask_o  = mem_mask(funct3_q, addr_q[2:0]);
        if (is_write_q) memReqWdata_o = store_data_q << {addr_q[2:0], 3'b000};
      end
      RESP: begin
        valid_o  = 1'b1;
        rdAddr_o = rd_addr_q;
        pID_o    = pid_q;
        if (!is_write_q) begin
          rdWriteEnable_o = rd_we_q;
          rdData_o        = load_data;
        end
      end
      default: ;
    endcase
  end

endmodule
